// File: rtl/game_pkg.sv
// game_pkg: shared state codes, answer-result encodings, damage verdicts
// and HP helpers for the round sequencer and its tick generator.
package game_pkg;

   // FSM state codes, exported on STATE for the displays
   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_SYNC  = 4'd1,
      ST_FETCH = 4'd2,
      ST_PLAY  = 4'd3,
      ST_JUDGE = 4'd4,
      ST_SHOW  = 4'd5,
      ST_OVER  = 4'd6
   } state_t;

   // answer result codes exchanged with the peer board
   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_OK   = 2'b01;
   localparam logic [1:0] RES_NG   = 2'b10;

   localparam int unsigned HP_W   = 4;
   localparam int unsigned TIME_W = 6;

   // who takes damage when the round is judged
   typedef enum logic [1:0] {
      DMG_NONE   = 2'd0,
      DMG_LOCAL  = 2'd1,
      DMG_REMOTE = 2'd2,
      DMG_BOTH   = 2'd3
   } dmg_t;

   // HP decrement saturating at zero
   function automatic logic [HP_W-1:0] hp_dec(input logic [HP_W-1:0] hp);
      return (hp == '0) ? hp : hp - HP_W'(1);
   endfunction

endpackage

// File: rtl/round_sequencer_sec_tick.sv
// sec_tick: free-running divider producing a 1-cycle tick every TICK_DIV
// clocks; a synchronous clear restarts the second from zero.
module sec_tick
   import game_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // divider counter, wraps at TICK_DIV-1 or restarts on clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || cnt == CNT_MAX) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == CNT_MAX) && !clr;

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: round-level sequencer for the two-board factorisation
// duel. Handshakes with the peer, requests questions, times the answer
// window, judges each round and keeps both HP counters in step.
// Optional feature macro: ROUND_TIMER_EN (answer-window timeout).
module round_sequencer
   import game_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned ROUND_SEC = 30,
   parameter int unsigned SHOW_SEC  = 2,
   parameter int unsigned HP_INIT   = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       READY_LOCAL,
   input  logic       READY_REMOTE,
   input  logic [1:0] RESULT_REMOTE,
   input  logic       Q_VALID,
   input  logic       ANS_DONE,
   input  logic       ANS_CORRECT,
   output logic       Q_REQ,
   output logic       READY_OUT,
   output logic [1:0] RESULT_OUT,
   output logic [3:0] STATE,
   output logic [5:0] TIME_LEFT,
   output logic [3:0] HP_LOCAL,
   output logic [3:0] HP_REMOTE,
   output logic       GAME_OVER,
   output logic       WIN
);

   if (ROUND_SEC > 63 || HP_INIT > 15 || SHOW_SEC > 63) begin : g_param_check
      $error("round_sequencer: parameter out of range");
   end

   localparam logic [HP_W-1:0]   HP_LOAD  = HP_W'(HP_INIT);
   localparam logic [TIME_W-1:0] SHOW_LEN = TIME_W'(SHOW_SEC);

   state_t            state;
   state_t            state_nxt;
   logic              ready_meta;
   logic              ready_sync;
   logic [1:0]        res_meta;
   logic [1:0]        res_sync;
   logic [1:0]        res_prev;
   logic [1:0]        remote_code;
   logic [1:0]        local_res;
   logic [1:0]        local_eff;
   logic              ans_now;
   logic              judge_go;
   dmg_t              verdict;
   dmg_t              dmg;
   logic              tick;
   logic              tick_clr;
   logic              timeout;
   logic              q_req;
   logic [TIME_W-1:0] time_left;
   logic [TIME_W-1:0] show_cnt;
   logic [HP_W-1:0]   hp_loc;
   logic [HP_W-1:0]   hp_rem;

   sec_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_sec_tick (
      .clk  (CLK),
      .rst  (RST),
      .clr  (tick_clr),
      .tick (tick)
   );

   // two-flop synchronisers for the peer GPIO lines, plus one history stage
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ready_meta <= 1'b0;
         ready_sync <= 1'b0;
         res_meta   <= RES_NONE;
         res_sync   <= RES_NONE;
         res_prev   <= RES_NONE;
      end else begin
         ready_meta <= READY_REMOTE;
         ready_sync <= ready_meta;
         res_meta   <= RESULT_REMOTE;
         res_sync   <= res_meta;
         res_prev   <= res_sync;
      end
   end

   // a remote code counts only once two consecutive synchronised samples agree
   assign remote_code = (res_sync == res_prev) ? res_sync : RES_NONE;

`ifdef ROUND_TIMER_EN
   localparam logic [TIME_W-1:0] ROUND_LEN = TIME_W'(ROUND_SEC);

   // answer-window countdown, loaded when the question arrives
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         time_left <= '0;
      end else if (state == ST_FETCH && Q_VALID) begin
         time_left <= ROUND_LEN;
      end else if (state == ST_PLAY && tick && time_left != '0) begin
         time_left <= time_left - 1'b1;
      end
   end

   assign timeout = (state == ST_PLAY) && (time_left == '0);
`else
   // no answer window: the countdown stays parked at zero
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         time_left <= '0;
      end else begin
         time_left <= '0;
      end
   end

   assign timeout = 1'b0;
`endif

   // state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic, round verdict and tick-counter restart
   always_comb begin
      state_nxt = state;
      tick_clr  = 1'b0;
      judge_go  = 1'b0;
      verdict   = DMG_NONE;
      ans_now   = ANS_DONE && (local_res == RES_NONE);
      local_eff = local_res;
      if (ans_now) begin
         local_eff = ANS_CORRECT ? RES_OK : RES_NG;
      end
      unique case (state)
         ST_IDLE: begin
            if (READY_LOCAL) state_nxt = ST_SYNC;
         end
         ST_SYNC: begin
            if (ready_sync) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (Q_VALID) begin
               state_nxt = ST_PLAY;
               tick_clr  = 1'b1;
            end
         end
         ST_PLAY: begin
            // a local answer in this cycle is judged together with the remote code
            judge_go = 1'b1;
            if (local_eff == RES_OK && remote_code == RES_OK) begin
               verdict = DMG_NONE;
            end else if (local_eff == RES_OK) begin
               verdict = DMG_REMOTE;
            end else if (remote_code == RES_OK) begin
               verdict = DMG_LOCAL;
            end else if (local_eff == RES_NG && remote_code == RES_NG) begin
               verdict = DMG_BOTH;
            end else if (timeout) begin
               verdict = DMG_BOTH;
            end else begin
               judge_go = 1'b0;
            end
            if (judge_go) state_nxt = ST_JUDGE;
         end
         ST_JUDGE: begin
            state_nxt = ST_SHOW;
            tick_clr  = 1'b1;
         end
         ST_SHOW: begin
            if (show_cnt == SHOW_LEN) begin
               state_nxt = (hp_loc == '0 || hp_rem == '0) ? ST_OVER : ST_SYNC;
            end
         end
         ST_OVER: begin
            if (READY_LOCAL) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // local answer latch; first submission of the round wins
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         local_res <= RES_NONE;
      end else if (state == ST_IDLE || state == ST_SYNC) begin
         local_res <= RES_NONE;
      end else if (state == ST_PLAY && ans_now) begin
         local_res <= local_eff;
      end
   end

   // verdict captured on leaving PLAY, applied in JUDGE
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dmg <= DMG_NONE;
      end else if (state == ST_PLAY && judge_go) begin
         dmg <= verdict;
      end
   end

   // HP counters: saturating damage in JUDGE, reload when leaving OVER
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hp_loc <= HP_LOAD;
         hp_rem <= HP_LOAD;
      end else if (state == ST_OVER && READY_LOCAL) begin
         hp_loc <= HP_LOAD;
         hp_rem <= HP_LOAD;
      end else if (state == ST_JUDGE) begin
         if (dmg == DMG_LOCAL || dmg == DMG_BOTH)  hp_loc <= hp_dec(hp_loc);
         if (dmg == DMG_REMOTE || dmg == DMG_BOTH) hp_rem <= hp_dec(hp_rem);
      end
   end

   // result display duration in ticks
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         show_cnt <= '0;
      end else if (state == ST_JUDGE) begin
         show_cnt <= '0;
      end else if (state == ST_SHOW && tick && show_cnt != SHOW_LEN) begin
         show_cnt <= show_cnt + 1'b1;
      end
   end

   // question request pulse on the SYNC -> FETCH edge
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_req <= 1'b0;
      end else begin
         q_req <= (state == ST_SYNC) && ready_sync;
      end
   end

   assign Q_REQ      = q_req;
   assign READY_OUT  = (state == ST_SYNC);
   assign RESULT_OUT = local_res;
   assign STATE      = state;
   assign TIME_LEFT  = time_left;
   assign HP_LOCAL   = hp_loc;
   assign HP_REMOTE  = hp_rem;
   assign GAME_OVER  = (state == ST_OVER);
   assign WIN        = (state == ST_OVER) && (hp_rem == '0) && (hp_loc != '0);

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed bench for round_sequencer with
// TICK_DIV=4, ROUND_SEC=3, SHOW_SEC=1, HP_INIT=2. Follows whichever
// ROUND_TIMER_EN setting the design is built with.
module tb_round_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       READY_LOCAL = 1'b0;
   logic       READY_REMOTE = 1'b0;
   logic [1:0] RESULT_REMOTE = 2'b00;
   logic       Q_VALID = 1'b0;
   logic       ANS_DONE = 1'b0;
   logic       ANS_CORRECT = 1'b0;
   logic       Q_REQ;
   logic       READY_OUT;
   logic [1:0] RESULT_OUT;
   logic [3:0] STATE;
   logic [5:0] TIME_LEFT;
   logic [3:0] HP_LOCAL;
   logic [3:0] HP_REMOTE;
   logic       GAME_OVER;
   logic       WIN;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

`ifdef ROUND_TIMER_EN
   localparam logic [31:0] T_START = 32'd3;
`else
   localparam logic [31:0] T_START = 32'd0;
`endif

   round_sequencer #(
      .TICK_DIV  (4),
      .ROUND_SEC (3),
      .SHOW_SEC  (1),
      .HP_INIT   (2)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .READY_LOCAL   (READY_LOCAL),
      .READY_REMOTE  (READY_REMOTE),
      .RESULT_REMOTE (RESULT_REMOTE),
      .Q_VALID       (Q_VALID),
      .ANS_DONE      (ANS_DONE),
      .ANS_CORRECT   (ANS_CORRECT),
      .Q_REQ         (Q_REQ),
      .READY_OUT     (READY_OUT),
      .RESULT_OUT    (RESULT_OUT),
      .STATE         (STATE),
      .TIME_LEFT     (TIME_LEFT),
      .HP_LOCAL      (HP_LOCAL),
      .HP_REMOTE     (HP_REMOTE),
      .GAME_OVER     (GAME_OVER),
      .WIN           (WIN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // inputs change and outputs are sampled on the falling edge
   task automatic step(input int unsigned n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic wait_state(input string tag, input logic [3:0] code, input int unsigned budget);
      int unsigned i = 0;
      while (STATE !== code && i < budget) begin
         step(1);
         i++;
      end
      check(tag, {28'd0, STATE}, {28'd0, code});
   endtask

   task automatic pulse_ready_local();
      READY_LOCAL = 1'b1;
      step(1);
      READY_LOCAL = 1'b0;
   endtask

   // handshake up to the first PLAY cycle
   task automatic start_round(input string tag);
      int unsigned nq = 0;
      if (STATE == 4'd0) pulse_ready_local();
      wait_state({tag, "_sync"}, 4'd1, 20);
      step(10);
      check({tag, "_ready_out_hi"}, {31'd0, READY_OUT}, 32'd1);
      READY_REMOTE = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (Q_REQ === 1'b1) nq++;
      end
      check({tag, "_q_req_count"}, nq, 32'd1);
      check({tag, "_fetch"}, {28'd0, STATE}, 32'd2);
      check({tag, "_ready_out_lo"}, {31'd0, READY_OUT}, 32'd0);
      Q_VALID = 1'b1;
      step(1);
      Q_VALID = 1'b0;
      READY_REMOTE = 1'b0;
      check({tag, "_play"}, {28'd0, STATE}, 32'd3);
      check({tag, "_time_start"}, {26'd0, TIME_LEFT}, T_START);
   endtask

   task automatic local_win(input string tag);
      ANS_DONE = 1'b1;
      ANS_CORRECT = 1'b1;
      step(1);
      ANS_DONE = 1'b0;
      ANS_CORRECT = 1'b0;
      check({tag, "_result_out"}, {30'd0, RESULT_OUT}, 32'd1);
      check({tag, "_judge"}, {28'd0, STATE}, 32'd4);
      step(1);
      check({tag, "_show"}, {28'd0, STATE}, 32'd5);
   endtask

`ifdef ROUND_TIMER_EN
   task automatic timeout_round(input string tag, input logic [31:0] hp_exp);
      step(4);
      check({tag, "_time2"}, {26'd0, TIME_LEFT}, 32'd2);
      step(4);
      check({tag, "_time1"}, {26'd0, TIME_LEFT}, 32'd1);
      step(4);
      check({tag, "_time0"}, {26'd0, TIME_LEFT}, 32'd0);
      check({tag, "_still_play"}, {28'd0, STATE}, 32'd3);
      step(1);
      check({tag, "_judge"}, {28'd0, STATE}, 32'd4);
      step(1);
      check({tag, "_hp_local"}, {28'd0, HP_LOCAL}, hp_exp);
      check({tag, "_hp_remote"}, {28'd0, HP_REMOTE}, hp_exp);
   endtask
`endif

   initial begin
      // reset state
      step(2);
      check("rst_state", {28'd0, STATE}, 32'd0);
      check("rst_q_req", {31'd0, Q_REQ}, 32'd0);
      check("rst_ready_out", {31'd0, READY_OUT}, 32'd0);
      check("rst_result_out", {30'd0, RESULT_OUT}, 32'd0);
      check("rst_time_left", {26'd0, TIME_LEFT}, 32'd0);
      check("rst_hp_local", {28'd0, HP_LOCAL}, 32'd2);
      check("rst_hp_remote", {28'd0, HP_REMOTE}, 32'd2);
      check("rst_game_over", {31'd0, GAME_OVER}, 32'd0);
      check("rst_win", {31'd0, WIN}, 32'd0);
      RST = 1'b0;
      step(2);

      // round 1: local correct answer, remote loses 1 HP
      start_round("r1");
      local_win("r1");
      check("r1_hp_local", {28'd0, HP_LOCAL}, 32'd2);
      check("r1_hp_remote", {28'd0, HP_REMOTE}, 32'd1);
      check("r1_result_hold", {30'd0, RESULT_OUT}, 32'd1);

      // round 2: remote glitch ignored, local wrong, repeat answer ignored, remote correct
      start_round("r2");
      RESULT_REMOTE = 2'b01;
      step(1);
      RESULT_REMOTE = 2'b00;
      step(3);
      check("r2_glitch_state", {28'd0, STATE}, 32'd3);
      check("r2_glitch_hp", {28'd0, HP_LOCAL}, 32'd2);
      ANS_DONE = 1'b1;
      ANS_CORRECT = 1'b0;
      step(1);
      ANS_DONE = 1'b0;
      check("r2_result_ng", {30'd0, RESULT_OUT}, 32'd2);
      check("r2_wait_remote", {28'd0, STATE}, 32'd3);
      ANS_DONE = 1'b1;
      ANS_CORRECT = 1'b1;
      step(1);
      ANS_DONE = 1'b0;
      ANS_CORRECT = 1'b0;
      check("r2_second_ans_ignored", {30'd0, RESULT_OUT}, 32'd2);
      check("r2_still_play", {28'd0, STATE}, 32'd3);
      RESULT_REMOTE = 2'b01;
      step(4);
      RESULT_REMOTE = 2'b00;
      wait_state("r2_show", 4'd5, 10);
      check("r2_hp_local", {28'd0, HP_LOCAL}, 32'd1);
      check("r2_hp_remote", {28'd0, HP_REMOTE}, 32'd1);

      // round 3: local and remote correct seen in the same cycle, tie
      start_round("r3");
      RESULT_REMOTE = 2'b01;
      step(3);
      check("r3_not_yet", {28'd0, STATE}, 32'd3);
      ANS_DONE = 1'b1;
      ANS_CORRECT = 1'b1;
      step(1);
      ANS_DONE = 1'b0;
      ANS_CORRECT = 1'b0;
      check("r3_judge", {28'd0, STATE}, 32'd4);
      step(1);
      RESULT_REMOTE = 2'b00;
      check("r3_show", {28'd0, STATE}, 32'd5);
      check("r3_hp_local", {28'd0, HP_LOCAL}, 32'd1);
      check("r3_hp_remote", {28'd0, HP_REMOTE}, 32'd1);

`ifdef ROUND_TIMER_EN
      // round 4: timeout takes both to 0, draw
      start_round("r4");
      timeout_round("r4", 32'd0);
      wait_state("r4_over", 4'd6, 20);
      check("r4_game_over", {31'd0, GAME_OVER}, 32'd1);
      check("r4_win", {31'd0, WIN}, 32'd0);
      pulse_ready_local();
      check("r4_idle", {28'd0, STATE}, 32'd0);
      check("r4_reload", {28'd0, HP_LOCAL}, 32'd2);

      // second game: two timeouts in a row end in a draw
      start_round("g2a");
      timeout_round("g2a", 32'd1);
      start_round("g2b");
      timeout_round("g2b", 32'd0);
      wait_state("g2_over", 4'd6, 20);
      check("g2_game_over", {31'd0, GAME_OVER}, 32'd1);
      check("g2_win", {31'd0, WIN}, 32'd0);
      pulse_ready_local();
      check("g2_idle", {28'd0, STATE}, 32'd0);
`else
      // round 4: no answer window, PLAY holds indefinitely
      start_round("r4");
      begin
         int unsigned np = 0;
         for (int i = 0; i < 100; i++) begin
            step(1);
            if (STATE === 4'd3 && TIME_LEFT === 6'd0) np++;
         end
         check("r4_play_persists", np, 32'd100);
      end
      local_win("r4");
      check("r4_hp_remote", {28'd0, HP_REMOTE}, 32'd0);
      wait_state("r4_over", 4'd6, 20);
      check("r4_game_over", {31'd0, GAME_OVER}, 32'd1);
      check("r4_win", {31'd0, WIN}, 32'd1);
      pulse_ready_local();
      check("r4_idle", {28'd0, STATE}, 32'd0);
      check("r4_reload_local", {28'd0, HP_LOCAL}, 32'd2);
      check("r4_reload_remote", {28'd0, HP_REMOTE}, 32'd2);
      check("r4_game_over_clr", {31'd0, GAME_OVER}, 32'd0);
`endif

      // reset in the middle of a round
      start_round("r5");
      pulse_ready_local();
      check("r5_ready_ignored", {28'd0, STATE}, 32'd3);
      ANS_DONE = 1'b1;
      ANS_CORRECT = 1'b0;
      step(1);
      ANS_DONE = 1'b0;
      check("r5_result_ng", {30'd0, RESULT_OUT}, 32'd2);
      #2 RST = 1'b1;
      step(1);
      check("r5_rst_state", {28'd0, STATE}, 32'd0);
      check("r5_rst_result", {30'd0, RESULT_OUT}, 32'd0);
      check("r5_rst_hp_local", {28'd0, HP_LOCAL}, 32'd2);
      check("r5_rst_hp_remote", {28'd0, HP_REMOTE}, 32'd2);
      RST = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
